// File: rtl/pair_cover_arbiter.sv
// Arbiter that grants between two urgent lanes and four pair-covered request groups.
// The groups rotate round-robin, and a starvation cap stops urgent traffic from locking them out.
module pair_cover_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] grp_data,
  input  logic [3:0]   grp_req,
  input  logic [3:0]   urg_data,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [2:0]   gnt_id,
  output logic [15:0]  gnt_count,
  output logic [5:0]   elig
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_nx;
  logic [1:0]  rr_ptr;
  logic [3:0]  starve_cnt;
  logic        grp_at_sel;
  logic [3:0]  grp_ok;
  logic [1:0]  urg_ok;
  logic [31:0] word;
  logic [15:0] pairs;
  logic [1:0]  idx;
  logic        rr_hit;
  logic [1:0]  rr_win;
  logic [2:0]  win;
  logic        load;
  logic        accept;

  // A group qualifies only when every one of its 16 pairs has at least one bit set.
  always_comb begin
    grp_ok = '0;
    word   = '0;
    pairs  = '0;
    for (int unsigned g = 0; g < 4; g++) begin
      word = grp_data[32*g +: 32];
      for (int unsigned k = 0; k < 16; k++) begin
        pairs[k] = word[2*k] | word[2*k+1];
      end
      grp_ok[g] = grp_req[g] & (&pairs);
    end
    urg_ok[0] = urg_data[0] | urg_data[1];
    urg_ok[1] = urg_data[2] | urg_data[3];
  end

  // Urgent lanes normally win; once starve_cnt reaches the cap, the round-robin group wins instead.
  always_comb begin
    rr_hit = 1'b0;
    rr_win = rr_ptr;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!rr_hit && elig[idx]) begin
        rr_hit = 1'b1;
        rr_win = idx;
      end
    end
    if (rr_hit && starve_cnt == LIMIT) win = {1'b0, rr_win};
    else if (elig[4])                  win = 3'd4;
    else if (elig[5])                  win = 3'd5;
    else                               win = {1'b0, rr_win};
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (|elig) begin
          load     = 1'b1;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          accept   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign gnt_valid = (state == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elig       <= '0;
      gnt_id     <= '0;
      gnt_count  <= '0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
      grp_at_sel <= 1'b0;
    end else begin
      elig <= {urg_ok, grp_ok};
      if (load) begin
        gnt_id     <= win;
        grp_at_sel <= |elig[3:0];
      end
      if (accept) begin
        if (gnt_count != '1) gnt_count <= gnt_count + 16'd1;
        if (!gnt_id[2]) begin
          rr_ptr     <= gnt_id[1:0] + 2'd1;
          starve_cnt <= '0;
        end else if (grp_at_sel && starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pair_cover_arbiter.sv
// Self-checking bench for pair_cover_arbiter.
// It uses an eligibility vector table, directed multi-cycle sequences and random traffic checked against a reference model.
module tb_pair_cover_arbiter;

  localparam int LIM = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] grp_data = '0;
  logic [3:0]   grp_req = '0;
  logic [3:0]   urg_data = '0;
  logic         gnt_ready = 1'b0;
  logic         gnt_valid;
  logic [2:0]   gnt_id;
  logic [15:0]  gnt_count;
  logic [5:0]   elig;

  int n_chk = 0;
  int n_fail = 0;

  pair_cover_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .grp_data(grp_data), .grp_req(grp_req),
    .urg_data(urg_data), .gnt_ready(gnt_ready), .gnt_valid(gnt_valid),
    .gnt_id(gnt_id), .gnt_count(gnt_count), .elig(elig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   req;
    logic [3:0]   urg;
    logic [5:0]   exp_elig;
  } vec_t;

  // reference model state
  logic       m_valid;
  int         m_id, m_count, m_rr, m_starve;
  logic       m_grpsel;
  logic [5:0] m_elig;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_valid = 1'b0; m_id = 0; m_count = 0; m_rr = 0; m_starve = 0;
    m_grpsel = 1'b0; m_elig = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    grp_data = '0; grp_req = '0; urg_data = '0; gnt_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    chk("rst_id",    32'(gnt_id),    32'd0);
    chk("rst_count", 32'(gnt_count), 32'd0);
    chk("rst_elig",  32'(elig),      32'd0);
    rst_n = 1'b1;
    m_reset();
  endtask

  function automatic logic [3:0] f_grp(input logic [127:0] d, input logic [3:0] r);
    logic [3:0] res;
    res = r;
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 16; k++)
        if (((d >> (32*g + 2*k)) & 128'd3) == 128'd0) res[g] = 1'b0;
    return res;
  endfunction

  function automatic logic [1:0] f_urg(input logic [3:0] u);
    return {u[3:2] != 2'b00, u[1:0] != 2'b00};
  endfunction

  function automatic int m_pick();
    int gw;
    gw = -1;
    for (int i = 0; i < 4; i++)
      if (gw < 0 && m_elig[(m_rr + i) % 4]) gw = (m_rr + i) % 4;
    if (gw >= 0 && m_starve == LIM) return gw;
    if (m_elig[4]) return 4;
    if (m_elig[5]) return 5;
    return gw;
  endfunction

  // Advance the model by one clock edge using the inputs that are currently applied.
  task automatic m_edge();
    logic [5:0] nxt;
    nxt = {f_urg(urg_data), f_grp(grp_data, grp_req)};
    if (m_valid) begin
      if (gnt_ready) begin
        m_valid = 1'b0;
        if (m_count < 65535) m_count++;
        if (m_id < 4) begin
          m_rr = (m_id + 1) % 4;
          m_starve = 0;
        end else if (m_grpsel && m_starve < LIM) m_starve++;
      end
    end else if (m_elig != 0) begin
      m_id = m_pick();
      m_grpsel = |m_elig[3:0];
      m_valid = 1'b1;
    end
    m_elig = nxt;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) w &= ~(32'h3 << (2 * $urandom_range(0, 15)));
    else if ($urandom_range(0, 3) == 0) w = 32'h5555_5555 | (32'hAAAA_AAAA & $urandom);
    return w;
  endfunction

  vec_t vt[7];
  int   ids28[5];
  int   ids29[6];

  initial begin
    vt[0] = '{{4{32'hFFFF_FFFF}}, 4'b1111, 4'b0000, 6'b001111};
    vt[1] = '{128'd0,             4'b1111, 4'b0000, 6'b000000};
    vt[2] = '{{4{32'hFFFF_FFFF}}, 4'b0000, 4'b0010, 6'b010000};
    vt[3] = '{{4{32'h5555_5555}}, 4'b1010, 4'b1000, 6'b101010};
    vt[4] = '{{4{32'hAAAA_AAAA}}, 4'b1111, 4'b0100, 6'b101111};
    vt[5] = '{{{3{32'hFFFF_FFFF}}, 32'h3FFF_FFFF}, 4'b1111, 4'b0000, 6'b001110};
    vt[6] = '{{32'hFFFF_FFFC, {3{32'hFFFF_FFFF}}}, 4'b1000, 4'b0011, 6'b010000};
    ids28 = '{0, 1, 2, 3, 0};
    ids29 = '{4, 4, 4, 4, 1, 4};

    do_reset();

    // eligibility table
    for (int i = 0; i < 7; i++) begin
      grp_data = vt[i].data; grp_req = vt[i].req; urg_data = vt[i].urg; gnt_ready = 1'b1;
      step();
      chk($sformatf("tbl_elig[%0d]", i), 32'(elig), 32'(vt[i].exp_elig));
    end

    // single group grant, two-edge latency, count after accept
    do_reset();
    grp_data = {4{32'hFFFF_FFFF}}; grp_req = 4'b0001; gnt_ready = 1'b1;
    step();
    chk("g0_edge1_valid", 32'(gnt_valid), 32'd0);
    chk("g0_edge1_elig",  32'(elig), 32'b000001);
    step();
    chk("g0_edge2_valid", 32'(gnt_valid), 32'd1);
    chk("g0_edge2_id",    32'(gnt_id), 32'd0);
    step();
    chk("g0_accept_valid", 32'(gnt_valid), 32'd0);
    chk("g0_accept_count", 32'(gnt_count), 32'd1);

    // uncovered pair blocks group 2 until one bit returns
    do_reset();
    grp_data = {32'hFFFF_FFFF, 32'hFFFF_3FFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    grp_req = 4'b0100; gnt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("g2_hole_elig",  32'(elig[2]), 32'd0);
      chk("g2_hole_valid", 32'(gnt_valid), 32'd0);
    end
    grp_data[95:64] = 32'hFFFF_7FFF;
    step();
    chk("g2_fill_elig", 32'(elig), 32'b000100);
    step();
    chk("g2_fill_valid", 32'(gnt_valid), 32'd1);
    chk("g2_fill_id",    32'(gnt_id), 32'd2);

    // round robin with one-cycle bubble
    do_reset();
    grp_data = {4{32'hFFFF_FFFF}}; grp_req = 4'b1111; gnt_ready = 1'b1;
    step();
    for (int n = 0; n < 5; n++) begin
      step();
      chk("rr_valid", 32'(gnt_valid), 32'd1);
      chk("rr_id",    32'(gnt_id), 32'(ids28[n]));
      step();
      chk("rr_bubble", 32'(gnt_valid), 32'd0);
    end

    // urgent lane held, starvation cap lets group 1 through
    do_reset();
    grp_data = {4{32'hFFFF_FFFF}}; grp_req = 4'b0010; urg_data = 4'b0001; gnt_ready = 1'b1;
    step();
    for (int n = 0; n < 6; n++) begin
      step();
      chk("starve_valid", 32'(gnt_valid), 32'd1);
      chk("starve_id",    32'(gnt_id), 32'(ids29[n]));
      step();
      chk("starve_bubble", 32'(gnt_valid), 32'd0);
    end

    // grant held stable under backpressure while requests toggle
    do_reset();
    grp_data = {4{32'hFFFF_FFFF}}; grp_req = 4'b0001; gnt_ready = 1'b0;
    step(); step();
    chk("hold_start_valid", 32'(gnt_valid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      grp_req = (n % 2 == 0) ? 4'b1110 : 4'b0000;
      urg_data = (n % 2 == 0) ? 4'b1111 : 4'b0000;
      step();
      chk("hold_valid", 32'(gnt_valid), 32'd1);
      chk("hold_id",    32'(gnt_id), 32'd0);
    end
    gnt_ready = 1'b1;
    step();
    chk("hold_accept_valid", 32'(gnt_valid), 32'd0);
    chk("hold_accept_count", 32'(gnt_count), 32'd1);

    // asynchronous reset in the middle of a grant
    do_reset();
    grp_data = {4{32'hFFFF_FFFF}}; grp_req = 4'b0001; gnt_ready = 1'b1;
    step(); step(); step();
    gnt_ready = 1'b0;
    step();
    chk("arst_pre_valid", 32'(gnt_valid), 32'd1);
    chk("arst_pre_count", 32'(gnt_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(gnt_valid), 32'd0);
    chk("arst_count", 32'(gnt_count), 32'd0);
    chk("arst_elig",  32'(elig), 32'd0);

    // random traffic against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      grp_data = {rand_word(), rand_word(), rand_word(), rand_word()};
      grp_req  = 4'($urandom);
      urg_data = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      gnt_ready = ($urandom_range(0, 2) != 0);
      m_edge();
      step();
      chk("rnd_valid", 32'(gnt_valid), 32'(m_valid));
      chk("rnd_elig",  32'(elig), 32'(m_elig));
      chk("rnd_count", 32'(gnt_count), 32'(m_count));
      if (m_valid) chk("rnd_id", 32'(gnt_id), 32'(m_id));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
